// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V datapath: control-state encodings,
// datapath widths and the architectural word type.
package riscv_pkg;

   localparam int unsigned REG_W    = 32;
   localparam int unsigned REGIDX_W = 5;
   localparam int unsigned NREG     = 32;

   localparam logic [3:0] EST_MEMRD = 4'b0011;
   localparam logic [3:0] EST_WB    = 4'b0100;
   localparam logic [3:0] EST_MEMWR = 4'b0110;
   localparam logic [3:0] EST_MEMWT = 4'b0111;

   typedef logic [REG_W-1:0]    word_t;
   typedef logic [REGIDX_W-1:0] regidx_t;

endpackage

// File: rtl/writeback_regfile_wb_mux.sv
// Write-back value selector; with WB_BYPASS_EN defined it also flags read ports
// that alias the register being committed this cycle.
module wb_mux
   import riscv_pkg::*;
(
   input  logic    memtoreg,
   input  word_t   reddataM,
   input  word_t   writedataR,
`ifdef WB_BYPASS_EN
   input  logic    wb_fire,
   input  logic    regwrite,
   input  regidx_t rd,
   input  regidx_t rs1,
   input  regidx_t rs2,
   input  regidx_t dbg_addr,
   output logic    hit1_c,
   output logic    hit2_c,
   output logic    hitd_c,
`endif
   output word_t   wdata_c
);

   assign wdata_c = memtoreg ? reddataM : writedataR;

`ifdef WB_BYPASS_EN
   logic wr_c;

   // A bypass only applies when this cycle actually commits a non-x0 register.
   assign wr_c   = wb_fire && regwrite && (rd != '0);
   assign hit1_c = wr_c && (rs1 == rd);
   assign hit2_c = wr_c && (rs2 == rd);
   assign hitd_c = wr_c && (dbg_addr == rd);
`endif

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage and 32x32 register file with retired-visit counter.
// Optional same-cycle read bypass enabled by defining WB_BYPASS_EN.
module writeback_regfile
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  estado,
   input  logic        regwrite,
   input  logic        memtoreg,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [31:0] reddataM,
   input  logic [31:0] writedataR,
   output logic [31:0] readdata1R,
   output logic [31:0] readdata2R,
   output logic [31:0] wb_data,
   output logic        wb_done,
   output logic [31:0] instret,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   word_t regs [NREG];
   logic  prev_wb;
   logic  is_wb_c;
   logic  wb_fire_c;
   word_t wdata_c;
   word_t rd1_c;
   word_t rd2_c;
   word_t rdd_c;

   // Only the first cycle of each write-back visit commits.
   assign is_wb_c   = (estado == EST_WB);
   assign wb_fire_c = is_wb_c && !prev_wb;

`ifdef WB_BYPASS_EN
   logic hit1_c, hit2_c, hitd_c;

   wb_mux u_wb_mux (
      .memtoreg   (memtoreg),
      .reddataM   (reddataM),
      .writedataR (writedataR),
      .wb_fire    (wb_fire_c),
      .regwrite   (regwrite),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .dbg_addr   (dbg_addr),
      .hit1_c     (hit1_c),
      .hit2_c     (hit2_c),
      .hitd_c     (hitd_c),
      .wdata_c    (wdata_c)
   );

   assign rd1_c = hit1_c ? wdata_c : regs[rs1];
   assign rd2_c = hit2_c ? wdata_c : regs[rs2];
   assign rdd_c = hitd_c ? wdata_c : regs[dbg_addr];
`else
   wb_mux u_wb_mux (
      .memtoreg   (memtoreg),
      .reddataM   (reddataM),
      .writedataR (writedataR),
      .wdata_c    (wdata_c)
   );

   assign rd1_c = regs[rs1];
   assign rd2_c = regs[rs2];
   assign rdd_c = regs[dbg_addr];
`endif

   // x0 reads as zero on every port independent of array contents.
   assign readdata1R = (rs1 == '0)      ? '0 : rd1_c;
   assign readdata2R = (rs2 == '0)      ? '0 : rd2_c;
   assign dbg_data   = (dbg_addr == '0) ? '0 : rdd_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         regs    <= '{default: '0};
         prev_wb <= 1'b0;
         wb_data <= '0;
         wb_done <= 1'b0;
         instret <= '0;
      end else begin
         prev_wb <= is_wb_c;
         wb_done <= wb_fire_c;
         if (wb_fire_c) begin
            wb_data <= wdata_c;
            instret <= instret + 32'd1;
            if (regwrite && (rd != '0)) begin
               regs[rd] <= wdata_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile (default or WB_BYPASS_EN build).
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  estado;
   logic        regwrite;
   logic        memtoreg;
   logic [4:0]  rs1, rs2, rd, dbg_addr;
   logic [31:0] reddataM, writedataR;
   logic [31:0] readdata1R, readdata2R, wb_data, instret, dbg_data;
   logic        wb_done;

   int nvec = 0;
   int nerr = 0;
   int pulses;

   always #5 clk = ~clk;

   writeback_regfile dut (
      .clk        (clk),
      .reset      (reset),
      .estado     (estado),
      .regwrite   (regwrite),
      .memtoreg   (memtoreg),
      .rs1        (rs1),
      .rs2        (rs2),
      .rd         (rd),
      .reddataM   (reddataM),
      .writedataR (writedataR),
      .readdata1R (readdata1R),
      .readdata2R (readdata2R),
      .wb_data    (wb_data),
      .wb_done    (wb_done),
      .instret    (instret),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [4:0] idx, output logic [31:0] val);
      dbg_addr = idx;
      #1;
      val = dbg_data;
   endtask

   logic [31:0] v;
   logic [3:0]  idle_codes [4];

   initial begin
      idle_codes[0] = 4'b0011; idle_codes[1] = 4'b0110;
      idle_codes[2] = 4'b0111; idle_codes[3] = 4'b1111;

      reset = 1'b1; estado = 4'd0; regwrite = 1'b0; memtoreg = 1'b0;
      rs1 = 5'd5; rs2 = 5'd9; rd = 5'd0; dbg_addr = 5'd7;
      reddataM = 32'h0; writedataR = 32'h0;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_rd1", readdata1R, 32'h0);
      chk("rst_rd2", readdata2R, 32'h0);
      chk("rst_dbg", dbg_data, 32'h0);
      chk("rst_instret", instret, 32'h0);
      chk("rst_wb_done", {31'h0, wb_done}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);

      // Non-write-back states must never commit.
      regwrite = 1'b1; memtoreg = 1'b1; rd = 5'd5; reddataM = 32'hAAAA_5555;
      writedataR = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         estado = idle_codes[i % 4];
         step();
      end
      estado = 4'd0;
      #1;
      chk("idle_x5", readdata1R, 32'h0);
      chk("idle_instret", instret, 32'h0);
      chk("idle_wb_done", {31'h0, wb_done}, 32'h0);

      // Load write-back into x5.
      estado = 4'b0100; memtoreg = 1'b1; regwrite = 1'b1; rd = 5'd5;
      reddataM = 32'hDEAD_BEEF; rs1 = 5'd5;
      @(negedge clk);
`ifdef WB_BYPASS_EN
      chk("load_same_cycle", readdata1R, 32'hDEAD_BEEF);
`else
      chk("load_same_cycle", readdata1R, 32'h0);
`endif
      step();
      estado = 4'd0;
      #1;
      chk("load_rd1", readdata1R, 32'hDEAD_BEEF);
      chk("load_wb_done", {31'h0, wb_done}, 32'h1);
      chk("load_instret", instret, 32'd1);
      chk("load_wb_data", wb_data, 32'hDEAD_BEEF);
      step();
      chk("load_wb_done_drop", {31'h0, wb_done}, 32'h0);

      // ALU write-back targeting x0.
      estado = 4'b0100; memtoreg = 1'b0; writedataR = 32'h12; reddataM = 32'hFFFF_FFFF;
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd5;
      step();
      estado = 4'd0;
      #1;
      chk("x0_rd1", readdata1R, 32'h0);
      chk("x0_wb_data", wb_data, 32'h12);
      chk("x0_instret", instret, 32'd2);
      chk("x0_x5_kept", readdata2R, 32'hDEAD_BEEF);
      peek(5'd0, v);
      chk("x0_dbg", v, 32'h0);
      step();

      // Held EST_WB: only the first cycle's value commits.
      estado = 4'b0100; rd = 5'd9; rs2 = 5'd9; pulses = 0;
      for (int i = 0; i < 4; i++) begin
         writedataR = 32'h100 + 32'(i);
         step();
         pulses += int'(wb_done);
      end
      estado = 4'd0;
      step();
      pulses += int'(wb_done);
      chk("held_pulses", 32'(pulses), 32'd1);
      chk("held_x9", readdata2R, 32'h100);
      chk("held_instret", instret, 32'd3);
      chk("held_wb_data", wb_data, 32'h100);

      // regwrite low: counter and wb_data advance, array does not.
      estado = 4'b0100; regwrite = 1'b0; rd = 5'd5; writedataR = 32'h77; rs1 = 5'd5;
      step();
      estado = 4'd0;
      #1;
      chk("norw_x5", readdata1R, 32'hDEAD_BEEF);
      chk("norw_wb_data", wb_data, 32'h77);
      chk("norw_instret", instret, 32'd4);
      step();

      // Reset coinciding with a wb_fire cycle wins.
      estado = 4'b0100; regwrite = 1'b1; rd = 5'd7; writedataR = 32'h99; reset = 1'b1;
      step();
      reset = 1'b0; estado = 4'd0;
      #1;
      peek(5'd7, v);
      chk("rstwb_x7", v, 32'h0);
      chk("rstwb_wb_done", {31'h0, wb_done}, 32'h0);
      chk("rstwb_instret", instret, 32'h0);
      chk("rstwb_x5", readdata1R, 32'h0);
      chk("rstwb_wb_data", wb_data, 32'h0);
      step();

      // Same-cycle read of the register being written.
      estado = 4'b0100; regwrite = 1'b1; memtoreg = 1'b0; rd = 5'd3; rs2 = 5'd3;
      writedataR = 32'h55;
      @(negedge clk);
`ifdef WB_BYPASS_EN
      chk("byp_rd2", readdata2R, 32'h55);
`else
      chk("byp_rd2", readdata2R, 32'h0);
`endif
      step();
      estado = 4'd0;
      #1;
      chk("byp_after", readdata2R, 32'h55);
      chk("byp_instret", instret, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Downstream neighbour of the data-memory stage in the multicycle RISC-V datapath.
- Consumes `reddataM` (load data) and `writedataR` (ALU result forwarded by memory) and selects the write-back value.
- Commits that value to a 32x32 register file and supplies the two source operands; `readdata2R` feeds the memory stage's store data.
- Gated by the shared 4-bit `estado` control state; counts retired write-back visits.

Parameters:
- EST_WB, 4'b0100, `estado` encoding of the write-back state.
- NREG, 32, number of architectural registers (x0 hardwired to zero).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- estado  in  4  current control-FSM state.
- regwrite  in  1  write-enable control for the current instruction.
- memtoreg  in  1  1 = write `reddataM`, 0 = write `writedataR`.
- rs1  in  5  source register 1 index.
- rs2  in  5  source register 2 index.
- rd  in  5  destination register index.
- reddataM  in  32  load data from memory stage.
- writedataR  in  32  ALU result from memory stage.
- readdata1R  out  32  contents of rs1 (combinational read).
- readdata2R  out  32  contents of rs2 (combinational read).
- wb_data  out  32  last value committed (registered).
- wb_done  out  1  one-cycle pulse after a write-back visit completes.
- instret  out  32  write-back visit counter.
- dbg_addr  in  5  debug read index.
- dbg_data  out  32  contents of register dbg_addr (combinational).

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, sampled only on `clk` rising edge.
- Reset values: all registers 0; wb_data 0; wb_done 0; instret 0; internal prev_wb 0.
- Reset precedence: reset during an EST_WB cycle wins; no write, no count, wb_done stays 0.
- State tracking:
  - Internal flag prev_wb <= (estado == EST_WB) every cycle.
  - wb_fire = (estado == EST_WB) && !prev_wb, i.e. the first cycle of each EST_WB visit.
  - Holding EST_WB for several cycles produces exactly one wb_fire.
- Write-back mux: wdata = memtoreg ? reddataM : writedataR.
- Commit on a wb_fire cycle's rising edge:
  - If regwrite && rd != 0: regs[rd] <= wdata.
  - wb_data <= wdata, regardless of regwrite.
  - instret <= instret + 1, modulo 2^32; 0xFFFFFFFF wraps to 0.
  - wb_done <= 1 on the following cycle only; otherwise 0.
- Register x0:
  - Never written.
  - Reads of index 0 on all read ports always return 0.
- Reads: readdata1R, readdata2R and dbg_data are asynchronous, driven from array contents.
- Outside EST_WB: no array or counter change regardless of regwrite/memtoreg.
- Same-cycle read/write hazard: without bypass, a read of rd in the wb_fire cycle returns the old value; the new value is visible from the next cycle.
- Unknown or unused `estado` codes are treated as non-write-back.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: in a wb_fire cycle with regwrite=1 and rd != 0, any read port (rs1, rs2, dbg_addr) whose index equals rd returns wdata combinationally.
- Undefined: reads return stored contents only, as described above.

Decomposition:
- Shared package `riscv_pkg` holds:
  - estado encodings: EST_WB plus the existing memory-access codes 4'b0011, 4'b0110, 4'b0111.
  - REG_W=32 and REGIDX_W=5 constants.
  - a typedef for the 32-bit word.
- One natural sub-module, `wb_mux`: the memtoreg 2:1 selector, with optional bypass compare logic.
- Array, edge detect and counter stay in the top.

Test Plan:
- Reset then idle: assert reset 2 cycles → all reads 0, instret 0, wb_done 0; with estado=4'b0011, regwrite=1 for 5 cycles → no register changes.
- Load write-back: estado=EST_WB, memtoreg=1, regwrite=1, rd=5, reddataM=0xDEADBEEF → next cycle rs1=5 reads 0xDEADBEEF, wb_done=1 for one cycle, instret=1.
- ALU write-back and x0: memtoreg=0, writedataR=0x12, rd=0 → x0 reads 0; wb_data=0x12; instret increments; no array change.
- Held state: estado=EST_WB for 4 cycles, writedataR changing each cycle → only the first-cycle value is written; instret +1 once; single wb_done pulse.
- Reset mid-operation: reset=1 in a wb_fire cycle with rd=7 → x7 remains 0, wb_done stays 0, instret 0.
- Bypass (WB_BYPASS_EN): wb_fire with rd=rs2=3, writedataR=0x55 → readdata2R=0x55 in the same cycle; without the macro, readdata2R shows the old value 0 in that cycle.
